// File: rtl/instr_encoder.sv
// instr_encoder: assembles mnemonic requests into 16-bit words and streams them into instruction memory
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [3:0]        r_dest,
  input  logic [3:0]        r_src,
  input  logic [15:0]       imm_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [1:0]        err_code
);
  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;
  state_t state, state_nx;
  logic [15:0] w1, w2, enc1, enc2;
  logic exp_r, expand, rng_bad, ill, sp_bad, acc, rej, good, sx, zx, err_r;
  logic [1:0] code, code_r;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] free, free_eff, cnt;
  assign sx = (&imm_in[15:7]) | ~(|imm_in[15:7]);
  assign zx = ~(|imm_in[15:8]);
  always_comb begin
    enc1 = '0;
    enc2 = '0;
    expand = 1'b0;
    rng_bad = 1'b0;
    ill = 1'b0;
    case (op_sel)
      5'd0:  enc1 = {4'b0000, r_dest, 4'b0101, r_src};
      5'd1:  enc1 = {4'b0000, r_dest, 4'b1001, r_src};
      5'd2:  enc1 = {4'b0000, r_dest, 4'b1110, r_src};
      5'd3:  enc1 = {4'b0000, r_dest, 4'b0010, r_src};
      5'd4:  enc1 = {4'b0000, r_dest, 4'b1011, r_src};
      5'd5:  enc1 = {4'b0000, r_dest, 4'b0001, r_src};
      5'd6:  enc1 = {4'b0000, r_dest, 4'b0011, r_src};
      5'd7:  enc1 = {4'b0000, r_dest, 4'b1101, r_src};
      5'd8:  enc1 = {4'b1000, r_dest, 4'b0100, r_src};
      5'd9:  enc1 = {4'b1000, r_dest, 4'b0110, r_src};
      5'd10: begin enc1 = {4'b0101, r_dest, imm_in[7:0]}; rng_bad = !sx; end
      5'd11: begin enc1 = {4'b1001, r_dest, imm_in[7:0]}; rng_bad = !sx; end
      5'd12: begin enc1 = {4'b1110, r_dest, imm_in[7:0]}; rng_bad = !sx; end
      5'd13: begin enc1 = {4'b1011, r_dest, imm_in[7:0]}; rng_bad = !sx; end
      5'd14: begin enc1 = {4'b0001, r_dest, imm_in[7:0]}; rng_bad = !zx; end
      5'd15: begin enc1 = {4'b0010, r_dest, imm_in[7:0]}; rng_bad = !zx; end
      5'd16: begin enc1 = {4'b0011, r_dest, imm_in[7:0]}; rng_bad = !zx; end
      5'd17: begin
        expand = !zx;
        enc1 = zx ? {4'b1101, r_dest, imm_in[7:0]} : {4'b1111, r_dest, imm_in[15:8]};
        enc2 = {4'b0010, r_dest, imm_in[7:0]};
      end
      5'd18: begin enc1 = {4'b1111, r_dest, imm_in[7:0]}; rng_bad = !zx; end
      5'd19: enc1 = {4'b0100, r_src, 4'b0000, r_dest};
      5'd20: enc1 = {4'b0100, r_src, 4'b0100, r_dest};
      5'd21: enc1 = {4'b0100, r_dest, 4'b1100, r_src};
      5'd22: enc1 = {4'b0100, r_dest, 4'b1000, r_src};
      5'd23: begin enc1 = {4'b1100, r_dest, imm_in[7:0]}; rng_bad = !sx; end
      default: ill = 1'b1;
    endcase
  end
  assign mem_we = !reset && !start && (state == WR1 || state == WR2);
  assign in_ready = !reset && !start && !(state == WR1 && exp_r);
  // space is judged after the write retiring this cycle
  assign free_eff = free - (ADDR_W+1)'(mem_we);
  assign sp_bad = (free_eff == '0) || (expand && free_eff == (ADDR_W+1)'(1));
  assign acc = in_valid && in_ready;
  assign rej = ill || rng_bad || sp_bad;
  assign good = acc && !rej;
  assign code = ill ? 2'b10 : rng_bad ? 2'b01 : 2'b11;
  always_comb state_nx = start ? IDLE : (state == WR1 && exp_r) ? WR2 : good ? WR1 : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      free <= {1'b1, {ADDR_W{1'b0}}};
      cnt <= '0;
      err_r <= 1'b0;
      code_r <= 2'b00;
      exp_r <= 1'b0;
      w1 <= '0;
      w2 <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr <= base_addr;
        free <= {1'b1, {ADDR_W{1'b0}}} - {1'b0, base_addr};
        cnt <= '0;
        err_r <= 1'b0;
        code_r <= 2'b00;
      end else begin
        if (mem_we) begin
          addr <= addr + ADDR_W'(1);
          free <= free - (ADDR_W+1)'(1);
          cnt <= cnt + (ADDR_W+1)'(1);
        end
        if (acc && rej) begin
          err_r <= 1'b1;
          if (!err_r) code_r <= code;
        end
      end
      if (good) begin
        w1 <= enc1;
        w2 <= enc2;
        exp_r <= expand;
      end
    end
  end
  assign mem_wdata = mem_we ? ((state == WR2) ? w2 : w1) : '0;
  assign mem_addr = reset ? '0 : addr;
  assign word_count = reset ? '0 : cnt;
  assign err = !reset && err_r;
  assign err_code = reset ? 2'b00 : code_r;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder at ADDR_W=8 and ADDR_W=4
module tb_instr_encoder;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, sel4 = 0;
  logic [7:0] base8 = 0;
  logic [4:0] op_sel = 0;
  logic [3:0] r_dest = 0, r_src = 0;
  logic [15:0] imm_in = 0;
  logic rdy8, we8, err8, rdy4, we4, err4;
  logic [7:0] addr8;
  logic [3:0] addr4;
  logic [15:0] wd8, wd4;
  logic [8:0] wc8;
  logic [4:0] wc4;
  logic [1:0] code8, code4;
  int checks = 0, failures = 0, cyc = 0;
  logic [23:0] q[$];
  logic [23:0] e;
  logic we_m;
  logic [7:0] a_m;
  logic [15:0] d_m;
  localparam logic [44:0] TBL [12] = '{
    {5'd10, 4'd2, 4'd0, 16'hFFFF, 16'h52FF},
    {5'd1,  4'd1, 4'd2, 16'h0000, 16'h0192},
    {5'd8,  4'd4, 4'd9, 16'h0000, 16'h8449},
    {5'd9,  4'd4, 4'd9, 16'h0000, 16'h8469},
    {5'd19, 4'd2, 4'd6, 16'h0000, 16'h4602},
    {5'd20, 4'd2, 4'd6, 16'h0000, 16'h4642},
    {5'd21, 4'd3, 4'd10, 16'h0000, 16'h43CA},
    {5'd22, 4'd15, 4'd1, 16'h0000, 16'h4F81},
    {5'd14, 4'd1, 4'd0, 16'h00AB, 16'h11AB},
    {5'd18, 4'd7, 4'd0, 16'h0012, 16'hF712},
    {5'd23, 4'd3, 4'd0, 16'hFFFE, 16'hC3FE},
    {5'd17, 4'd5, 4'd0, 16'h00FF, 16'hD5FF}
  };

  instr_encoder dut8 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base8), .in_valid(in_valid),
    .in_ready(rdy8), .op_sel(op_sel), .r_dest(r_dest), .r_src(r_src), .imm_in(imm_in),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8), .word_count(wc8), .err(err8), .err_code(code8)
  );
  instr_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base8[3:0]), .in_valid(in_valid),
    .in_ready(rdy4), .op_sel(op_sel), .r_dest(r_dest), .r_src(r_src), .imm_in(imm_in),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wd4), .word_count(wc4), .err(err4), .err_code(code4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    we_m = sel4 ? we4 : we8;
    a_m = sel4 ? {4'h0, addr4} : addr8;
    d_m = sel4 ? wd4 : wd8;
    if (we_m) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h", a_m, d_m);
      end else begin
        e = q.pop_front();
        if ({a_m, d_m} !== e) begin
          failures++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h", a_m, d_m, e[23:16], e[15:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [7:0] b);
    in_valid = 0;
    start = 1;
    base8 = b;
    #1;
    checks++;
    if ((sel4 ? rdy4 : rdy8) !== 1'b0) begin failures++; $display("FAIL ready_in_start got=1 exp=0"); end
    @(posedge clk); #1;
    start = 0;
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm);
    int n;
    op_sel = op; r_dest = rd; r_src = rs; imm_in = imm; in_valid = 1;
    n = 0;
    while (!(sel4 ? rdy4 : rdy8) && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) begin checks++; failures++; $display("FAIL ready_timeout op=%0d", op); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({rdy8, we8, err8, code8} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {rdy8, we8, err8, code8}); end
    checks++;
    if ({addr8, wd8, wc8} !== 33'b0) begin failures++; $display("FAIL reset_data got=%h exp=0", {addr8, wd8, wc8}); end
    reset = 0;
    #1;
    checks++;
    if (rdy8 !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", rdy8); end
    pulse(8'h40);
    q.push_back({8'h40, 16'hF412});
    send(5'd17, 4'd4, 4'd0, 16'h1234);
    in_valid = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    idle(2);
    checks++;
    if ({addr8, wc8} !== 17'b0) begin failures++; $display("FAIL reset_mid_expand got addr=%h wc=%0d exp 0", addr8, wc8); end
  endtask

  task automatic test_start_add;
    pulse(8'h10);
    q.push_back({8'h10, 16'h0355});
    send(5'd0, 4'd3, 4'd5, 16'h0);
    checks++;
    if (we8 !== 1'b1) begin failures++; $display("FAIL latency got we=%b exp=1", we8); end
    idle(1);
    checks++;
    if ({wc8, addr8} !== {9'd1, 8'h11}) begin failures++; $display("FAIL after_add got wc=%0d addr=%h exp wc=1 addr=11", wc8, addr8); end
  endtask

  task automatic test_back_to_back;
    logic [44:0] t;
    int c0;
    pulse(8'h30);
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      t = TBL[i];
      q.push_back({8'h30 + 8'(i), t[15:0]});
      send(t[44:40], t[39:36], t[35:32], t[31:16]);
    end
    checks++;
    if (cyc - c0 != 12) begin failures++; $display("FAIL throughput got=%0d cycles exp=12", cyc - c0); end
    idle(3);
    checks++;
    if (wc8 !== 9'd12) begin failures++; $display("FAIL b2b_count got=%0d exp=12", wc8); end
  endtask

  task automatic test_movi;
    pulse(8'h50);
    q.push_back({8'h50, 16'hF412});
    q.push_back({8'h51, 16'h2434});
    q.push_back({8'h52, 16'h0355});
    send(5'd17, 4'd4, 4'd0, 16'h1234);
    checks++;
    if ({we8, rdy8} !== 2'b10) begin failures++; $display("FAIL movi_first got we,rdy=%b exp=10", {we8, rdy8}); end
    send(5'd0, 4'd3, 4'd5, 16'h0);
    idle(3);
    checks++;
    if (wc8 !== 9'd3) begin failures++; $display("FAIL movi_count got=%0d exp=3", wc8); end
  endtask

  task automatic test_errors;
    pulse(8'h20);
    send(5'd10, 4'd1, 4'd0, 16'd200);
    checks++;
    if ({err8, code8, addr8} !== {1'b1, 2'b01, 8'h20}) begin failures++; $display("FAIL range_err got err=%b code=%b addr=%h exp 1 01 20", err8, code8, addr8); end
    q.push_back({8'h20, 16'h0355});
    send(5'd0, 4'd3, 4'd5, 16'h0);
    send(5'd25, 4'd0, 4'd0, 16'h0);
    checks++;
    if (code8 !== 2'b01) begin failures++; $display("FAIL first_err_kept got=%b exp=01", code8); end
    idle(2);
    pulse(8'h20);
    checks++;
    if ({err8, code8} !== 3'b000) begin failures++; $display("FAIL start_clears got=%b exp=000", {err8, code8}); end
    send(5'd25, 4'd0, 4'd0, 16'h0);
    send(5'd14, 4'd1, 4'd0, 16'h0100);
    checks++;
    if ({err8, code8} !== 3'b110) begin failures++; $display("FAIL illegal_op got=%b exp=110", {err8, code8}); end
    idle(2);
    checks++;
    if ({wc8, addr8} !== {9'd0, 8'h20}) begin failures++; $display("FAIL no_write_on_reject got wc=%0d addr=%h exp 0 20", wc8, addr8); end
  endtask

  task automatic test_full;
    idle(2);
    sel4 = 1;
    pulse(8'h0F);
    q.push_back({8'h0F, 16'h0355});
    send(5'd0, 4'd3, 4'd5, 16'h0);
    send(5'd0, 4'd3, 4'd5, 16'h0);
    checks++;
    if ({err4, code4} !== 3'b111) begin failures++; $display("FAIL full_reject got=%b exp=111", {err4, code4}); end
    idle(2);
    checks++;
    if ({wc4, addr4} !== {5'd1, 4'h0}) begin failures++; $display("FAIL wrap got wc=%0d addr=%h exp 1 0", wc4, addr4); end
    pulse(8'h0F);
    send(5'd17, 4'd4, 4'd0, 16'h1234);
    idle(2);
    checks++;
    if ({err4, code4, wc4} !== {3'b111, 5'd0}) begin failures++; $display("FAIL movi_one_slot got err=%b code=%b wc=%0d exp 1 11 0", err4, code4, wc4); end
    pulse(8'h0E);
    q.push_back({8'h0E, 16'hF412});
    q.push_back({8'h0F, 16'h2434});
    send(5'd17, 4'd4, 4'd0, 16'h1234);
    idle(3);
    checks++;
    if ({err4, wc4, addr4} !== {1'b0, 5'd2, 4'h0}) begin failures++; $display("FAIL movi_two_slots got err=%b wc=%0d addr=%h exp 0 2 0", err4, wc4, addr4); end
    sel4 = 0;
  endtask

  initial begin
    test_reset();
    test_start_add();
    test_back_to_back();
    test_movi();
    test_errors();
    test_full();
    idle(2);
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL missing_writes got=%0d pending exp=0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
